regfile_sequencer: RTL

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

---
 rtl/regfile_seq_pkg.sv | 22 ++
 rtl/onehot_dec3.sv | 13 +
 rtl/regfile_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/regfile_seq_pkg.sv
// Shared constants and state encoding for the register-file sequencer.
package regfile_seq_pkg;

  localparam int NUM_REGS   = 8;
  localparam int REG_SEL_W  = 3;
  localparam int WAIT_CNT_W = 8;

  localparam logic [1:0] OP_ALU   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ALU_WAIT = 3'd1,
    LD_WAIT  = 3'd2,
    ST       = 3'd3,
    WB       = 3'd4,
    NOP_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/onehot_dec3.sv
// 3-bit index to 8-bit one-hot decoder with enable; all zeros when disabled.
module onehot_dec3 (
  input  logic [2:0] idx,
  input  logic       en,
  output logic [7:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Command sequencer driving ALU, RAM and register-file load strobes; all outputs registered.
// Optional wait-state timeout abort is enabled by defining SEQ_TIMEOUT_EN.
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TMO_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE and the command fields are captured on that edge.
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [REG_SEL_W-1:0] cmd_rd,
  input  logic [REG_SEL_W-1:0] cmd_rs1,
  input  logic [REG_SEL_W-1:0] cmd_rs2,
  input  logic [ADDR_W-1:0]    cmd_addr,
  output logic                 alu_start,
  input  logic                 alu_done,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic                 ram_re,
  output logic                 ram_we,
  input  logic                 ram_rdy,
  output logic [NUM_REGS-1:0]  ldR,
  output logic [NUM_REGS-1:0]  ldALU,
  output logic [REG_SEL_W-1:0] selrd1,
  output logic [REG_SEL_W-1:0] selrd2,
  output logic [REG_SEL_W-1:0] selram,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [2:0]           dbg_state
);

`ifdef SEQ_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif
  localparam logic [WAIT_CNT_W-1:0] TMO_LAST = WAIT_CNT_W'(TMO_CYC - 1);

  state_t                 state, nxt;
  logic [1:0]             op_q;
  logic [REG_SEL_W-1:0]   rd_q;
  logic [WAIT_CNT_W-1:0]  wait_cnt;
  logic                   accept;
  logic                   tmo_hit;
  logic                   abort;
  logic [NUM_REGS-1:0]    ld_ram_d;
  logic [NUM_REGS-1:0]    ld_alu_d;

  assign accept    = cmd_valid && cmd_ready;
  assign tmo_hit   = TMO_ON && (wait_cnt == TMO_LAST);
  assign dbg_state = state;

  // An ack in the last allowed wait cycle still wins over the timeout.
  always_comb begin
    nxt   = state;
    abort = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_ALU:   nxt = ALU_WAIT;
            OP_LOAD:  nxt = LD_WAIT;
            OP_STORE: nxt = ST;
            default:  nxt = NOP_DONE;
          endcase
        end
      end
      ALU_WAIT: begin
        if (alu_done) nxt = WB;
        else if (tmo_hit) begin
          nxt   = IDLE;
          abort = 1'b1;
        end
      end
      LD_WAIT: begin
        if (ram_rdy) nxt = WB;
        else if (tmo_hit) begin
          nxt   = IDLE;
          abort = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  onehot_dec3 u_dec_ram (
    .idx    (rd_q),
    .en     (nxt == WB && op_q == OP_LOAD),
    .onehot (ld_ram_d)
  );

  onehot_dec3 u_dec_alu (
    .idx    (rd_q),
    .en     (nxt == WB && op_q == OP_ALU),
    .onehot (ld_alu_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      wait_cnt  <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      alu_start <= 1'b0;
      ram_re    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ldR       <= '0;
      ldALU     <= '0;
      selrd1    <= '0;
      selrd2    <= '0;
      selram    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= nxt;
      cmd_ready <= (nxt == IDLE);
      busy      <= (nxt != IDLE);
      alu_start <= (state == IDLE) && (nxt == ALU_WAIT);
      ram_re    <= (nxt == LD_WAIT);
      ram_we    <= (nxt == ST);
      done      <= (nxt == WB) || (nxt == ST) || (nxt == NOP_DONE);
      err       <= abort;
      ldR       <= ld_ram_d;
      ldALU     <= ld_alu_d;

      if (state == ALU_WAIT || state == LD_WAIT) wait_cnt <= wait_cnt + 1'b1;
      else                                       wait_cnt <= '0;

      // Selects and address are loaded only at acceptance and otherwise hold.
      if (accept) begin
        op_q <= cmd_op;
        rd_q <= cmd_rd;
        if (cmd_op == OP_ALU) begin
          selrd1 <= cmd_rs1;
          selrd2 <= cmd_rs2;
        end
        if (cmd_op == OP_STORE) selram <= cmd_rs1;
        if (cmd_op == OP_LOAD || cmd_op == OP_STORE) ram_addr <= cmd_addr;
      end
    end
  end

endmodule
